// File: rtl/cpe142_pkg.sv
// Shared CPE142 definitions: opcodes, funct codes, ALUOp and pc_src encodings, control states.
package cpe142_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned FUNCT_W = 4;

  localparam logic [OPC_W-1:0] OPC_TYPEA = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_LW    = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_SW    = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_BLT   = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_BGT   = 4'b0101;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_JMP   = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_HALT  = 4'b1111;

  localparam logic [FUNCT_W-1:0] FUNCT_MUL = 4'b0001;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV = 4'b0010;

  localparam logic [1:0] OP_TYPEA = 2'b00;
  localparam logic [1:0] OP_TYPEB = 2'b10;
  localparam logic [1:0] OP_TYPEC = 2'b01;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_START   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_MD_WAIT = 4'd4,
    S_MEM     = 4'd5,
    S_WB      = 4'd6,
    S_BRANCH  = 4'd7,
    S_HALT    = 4'd8
  } state_e;

  function automatic logic is_cond_branch(input logic [OPC_W-1:0] op);
    return (op == OPC_BLT) || (op == OPC_BGT) || (op == OPC_BEQ);
  endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit: sequences fetch/decode/execute/memory/write-back
// and drives datapath enables, ALUOp and mul/div / memory hand-shakes.
module main_control_fsm
  import cpe142_pkg::*;
#(
  parameter int unsigned OPW = 4,
  parameter int unsigned FW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  funct,
  input  logic           alu_done,
  input  logic           mem_ready,
  input  logic           branch_taken,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           ALUOp1,
  output logic           ALUOp0,
  output logic           alu_src_b,
  output logic           alu_start,
  output logic           mem_read,
  output logic           mem_write,
  output logic           reg_write,
  output logic           mem_to_reg,
  output logic           halted,
  output logic           illegal
);

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   illegal_q, illegal_d;
  logic [1:0] aluop_c;

  logic [OPC_W-1:0]   op_c;
  logic [FUNCT_W-1:0] fn_c;
  logic is_typea_c, is_lw_c, is_sw_c, is_mem_c, is_md_c, is_jmp_c, is_br_c, is_halt_c;

  assign op_c       = OPC_W'(opcode);
  assign fn_c       = FUNCT_W'(funct);
  assign is_typea_c = (op_c == OPC_TYPEA);
  assign is_lw_c    = (op_c == OPC_LW);
  assign is_sw_c    = (op_c == OPC_SW);
  assign is_mem_c   = is_lw_c || is_sw_c;
  assign is_md_c    = is_typea_c && ((fn_c == FUNCT_MUL) || (fn_c == FUNCT_DIV));
  assign is_jmp_c   = (op_c == OPC_JMP);
  assign is_br_c    = is_cond_branch(op_c);
  assign is_halt_c  = (op_c == OPC_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_START;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; the status flags are set on entry to HALT and only reset clears them.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_typea_c || is_mem_c) begin
          state_d = S_EXEC;
        end else if (is_br_c || is_jmp_c) begin
          state_d = S_BRANCH;
        end else begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          if (!is_halt_c) illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_mem_c)     state_d = S_MEM;
        else if (is_md_c) state_d = S_MD_WAIT;
        else              state_d = S_WB;
      end
      S_MD_WAIT: if (alu_done) state_d = S_WB;
      S_MEM:     if (mem_ready) state_d = is_lw_c ? S_WB : S_FETCH;
      S_WB:      state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_START;
    endcase
  end

  // Moore output decoder; only pc_write in BRANCH looks at a live input.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_INC;
    aluop_c    = OP_TYPEB;
    alu_src_b  = 1'b0;
    alu_start  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      S_START: aluop_c = OP_TYPEA;
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_EXEC: begin
        aluop_c   = is_mem_c ? OP_TYPEB : OP_TYPEA;
        alu_src_b = is_mem_c;
        alu_start = is_md_c;
      end
      S_MD_WAIT: aluop_c = OP_TYPEA;
      S_MEM: begin
        alu_src_b = 1'b1;
        mem_read  = is_lw_c;
        mem_write = is_sw_c;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw_c;
      end
      S_BRANCH: begin
        aluop_c = OP_TYPEC;
        if (is_jmp_c) begin
          pc_src   = PC_SRC_JUMP;
          pc_write = 1'b1;
        end else begin
          pc_src   = PC_SRC_BRANCH;
          pc_write = branch_taken;
        end
      end
      default: ;
    endcase
  end

  assign ALUOp1  = aluop_c[1];
  assign ALUOp0  = aluop_c[0];
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule
